// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter sharing one AXI-Stream sink between NUM_INPUTS requesters.
// Grants bursts of up to MAX_BURST beats through a registered output stage tagged with tid.
module axis_rr_arbiter #(
  parameter int unsigned NUM_INPUTS        = 2,
  parameter int unsigned TDATA_WIDTH_BYTES = 4,
  parameter int unsigned MAX_BURST         = 4,
  localparam int unsigned DataW = 8 * TDATA_WIDTH_BYTES,
  localparam int unsigned IdW   = (NUM_INPUTS > 2) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                        aclk,
  input  logic                        resetn,
  input  logic [NUM_INPUTS-1:0]       s_axis_tvalid,
  output logic [NUM_INPUTS-1:0]       s_axis_tready,
  input  logic [NUM_INPUTS*DataW-1:0] s_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [DataW-1:0]            m_axis_tdata,
  output logic [IdW-1:0]              m_axis_tid
);

  localparam int unsigned CntW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [IdW-1:0]    r_grant_idx;
  logic [IdW-1:0]    w_grant_nxt;
  logic [IdW-1:0]    r_last_grant;
  logic [IdW-1:0]    w_last_nxt;
  logic [CntW-1:0]   r_beat_cnt;
  logic [CntW-1:0]   w_cnt_nxt;

  logic              r_m_tvalid;
  logic [DataW-1:0]  r_m_tdata;
  logic [IdW-1:0]    r_m_tid;

  logic              w_out_free;
  logic              w_sel_valid;
  logic [DataW-1:0]  w_sel_data;
  logic              w_hs;
  logic              w_pick_found;
  logic [IdW-1:0]    w_pick_idx;
  logic [NUM_INPUTS-1:0] w_tready;

  assign w_out_free  = !r_m_tvalid || m_axis_tready;
  assign w_sel_valid = s_axis_tvalid[r_grant_idx];
  assign w_sel_data  = s_axis_tdata[int'(r_grant_idx) * int'(DataW) +: DataW];
  assign w_hs        = (r_state == StGrant) && w_out_free && w_sel_valid;

  // Scan downward so the candidate closest after last_grant is the one that sticks.
  always_comb begin
    logic [IdW-1:0] cand;
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    cand         = '0;
    for (int k = int'(NUM_INPUTS); k >= 1; k--) begin
      cand = IdW'((int'(r_last_grant) + k) % int'(NUM_INPUTS));
      if (s_axis_tvalid[cand]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = cand;
      end
    end
  end

  always_comb begin
    w_tready = '0;
    if (r_state == StGrant && w_out_free) begin
      w_tready[r_grant_idx] = 1'b1;
    end
  end

  assign s_axis_tready = w_tready;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_idx;
    w_last_nxt  = r_last_grant;
    w_cnt_nxt   = r_beat_cnt;
    case (r_state)
      StIdle: begin
        if (w_pick_found) begin
          w_grant_nxt = w_pick_idx;
          w_cnt_nxt   = '0;
          w_state_nxt = StGrant;
        end
      end
      StGrant: begin
        // Release on the final beat of a burst or when the holder idles with room downstream.
        if ((w_hs && r_beat_cnt == CntW'(MAX_BURST - 1)) || (w_out_free && !w_sel_valid)) begin
          w_state_nxt = StIdle;
          w_last_nxt  = r_grant_idx;
          w_cnt_nxt   = '0;
        end else if (w_hs) begin
          w_cnt_nxt = r_beat_cnt + 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= StIdle;
      r_grant_idx  <= '0;
      r_last_grant <= IdW'(NUM_INPUTS - 1);
      r_beat_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_idx  <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
      r_beat_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tid    <= '0;
    end else if (w_hs) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= w_sel_data;
      r_m_tid    <= r_grant_idx;
    end else if (m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tid    = r_m_tid;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: queue-driven sources, expected beats checked in order.
module tb_axis_rr_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned MB = 4;

  logic            aclk = 1'b0;
  logic            resetn;
  logic [N-1:0]    s_valid;
  logic [N-1:0]    s_ready;
  logic [N*DW-1:0] s_data;
  logic            m_valid;
  logic            m_ready;
  logic [DW-1:0]   m_data;
  logic [0:0]      m_tid;

  always #5 aclk = ~aclk;

  axis_rr_arbiter #(
    .NUM_INPUTS       (N),
    .TDATA_WIDTH_BYTES(DW / 8),
    .MAX_BURST        (MB)
  ) u_dut (
    .aclk         (aclk),
    .resetn       (resetn),
    .s_axis_tvalid(s_valid),
    .s_axis_tready(s_ready),
    .s_axis_tdata (s_data),
    .m_axis_tvalid(m_valid),
    .m_axis_tready(m_ready),
    .m_axis_tdata (m_data),
    .m_axis_tid   (m_tid)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [0:0]  tid;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] src_q[N][$];
  int          out_cyc[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          out_cnt = 0;
  int          cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic t);
    exp_q.push_back(beat_t'{data: d, tid: t});
  endtask

  function automatic int pending();
    int n;
    n = exp_q.size();
    for (int i = 0; i < N; i++) n += src_q[i].size();
    return n;
  endfunction

  task automatic drive_srcs();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        s_valid[i]           = 1'b1;
        s_data[i*DW +: DW]   = src_q[i][0];
      end else begin
        s_valid[i]           = 1'b0;
        s_data[i*DW +: DW]   = '0;
      end
    end
  endtask

  // One clock: sample at negedge, then advance sources past the posedge.
  task automatic step();
    logic [N-1:0] hs;
    beat_t        b;
    @(negedge aclk);
    hs = s_valid & s_ready;
    if (m_valid && m_ready) begin
      out_cyc.push_back(cyc);
      out_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("beat_expected", 64'(exp_q.size()), 64'd1);
      end else begin
        b = exp_q.pop_front();
        check_eq("tdata", 64'(m_data), 64'(b.data));
        check_eq("tid", 64'(m_tid), 64'(b.tid));
      end
    end
    @(posedge aclk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) void'(src_q[i].pop_front());
    end
    drive_srcs();
    cyc++;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 300;
    while ((pending() > 0 || m_valid) && budget > 0) begin
      step();
      budget--;
    end
    check_eq({tag, "_left"}, 64'(pending()), 64'd0);
  endtask

  task automatic wait_beats(input string tag, input int n);
    int budget;
    budget = 100;
    while (out_cnt < n && budget > 0) begin
      step();
      budget--;
    end
    check_eq({tag, "_beats_seen"}, 64'(out_cnt), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetn  = 1'b0;
    m_ready = 1'b1;
    s_valid = '0;
    s_data  = '0;

    // Reset with both requesters valid; requester 0 must win first afterwards.
    src_q[0].push_back(32'h01);
    src_q[1].push_back(32'h02);
    drive_srcs();
    repeat (5) begin
      step();
      check_eq("rst_tvalid", 64'(m_valid), 64'd0);
      check_eq("rst_tready", 64'(s_ready), 64'd0);
    end
    check_eq("rst_tdata", 64'(m_data), 64'd0);
    check_eq("rst_tid", 64'(m_tid), 64'd0);
    push_exp(32'h01, 1'b0);
    push_exp(32'h02, 1'b1);
    resetn = 1'b1;
    drain("t1");

    // Single requester streaming 8 beats: one bubble after the 4th.
    out_cyc.delete();
    for (int k = 0; k < 8; k++) begin
      src_q[1].push_back(32'h10 + k);
      push_exp(32'h10 + k, 1'b1);
    end
    drive_srcs();
    drain("t2");
    check_eq("t2_count", 64'(out_cyc.size()), 64'd8);
    for (int i = 0; i + 1 < out_cyc.size(); i++) begin
      check_eq("t2_gap", 64'(out_cyc[i+1] - out_cyc[i]), (i == 3) ? 64'd2 : 64'd1);
    end

    // Both continuous: bursts of four alternate.
    for (int k = 0; k < 8; k++) begin
      src_q[0].push_back(32'hA0 + k);
      src_q[1].push_back(32'hB0 + k);
    end
    for (int k = 0; k < 4; k++) push_exp(32'hA0 + k, 1'b0);
    for (int k = 0; k < 4; k++) push_exp(32'hB0 + k, 1'b1);
    for (int k = 4; k < 8; k++) push_exp(32'hA0 + k, 1'b0);
    for (int k = 4; k < 8; k++) push_exp(32'hB0 + k, 1'b1);
    drive_srcs();
    drain("t3");

    // Early release: requester 0 sends two beats then drops valid.
    src_q[0].push_back(32'hC0);
    src_q[0].push_back(32'hC1);
    for (int k = 0; k < 3; k++) src_q[1].push_back(32'hD0 + k);
    push_exp(32'hC0, 1'b0);
    push_exp(32'hC1, 1'b0);
    for (int k = 0; k < 3; k++) push_exp(32'hD0 + k, 1'b1);
    drive_srcs();
    drain("t4");

    // Backpressure for 10 cycles mid-burst; E2 must sit in the output register.
    for (int k = 0; k < 4; k++) begin
      src_q[0].push_back(32'hE0 + k);
      push_exp(32'hE0 + k, 1'b0);
    end
    drive_srcs();
    out_cnt = 0;
    wait_beats("t5", 2);
    m_ready = 1'b0;
    repeat (10) begin
      step();
      check_eq("t5_hold_valid", 64'(m_valid), 64'd1);
      check_eq("t5_hold_data", 64'(m_data), 64'hE2);
      check_eq("t5_hold_tid", 64'(m_tid), 64'd0);
      check_eq("t5_hold_tready", 64'(s_ready), 64'd0);
    end
    m_ready = 1'b1;
    drain("t5");

    // Reset mid-burst of requester 1; in-flight G2 is discarded, requester 0 wins after.
    for (int k = 0; k < 4; k++) begin
      src_q[0].push_back(32'hF0 + k);
      src_q[1].push_back(32'h60 + k);
    end
    push_exp(32'h60, 1'b1);
    push_exp(32'h61, 1'b1);
    drive_srcs();
    out_cnt = 0;
    wait_beats("t6", 2);
    resetn = 1'b0;
    #1;
    check_eq("t6_rst_tvalid", 64'(m_valid), 64'd0);
    check_eq("t6_rst_tready", 64'(s_ready), 64'd0);
    check_eq("t6_rst_tdata", 64'(m_data), 64'd0);
    check_eq("t6_rst_tid", 64'(m_tid), 64'd0);
    check_eq("t6_exp_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (2) step();
    for (int k = 0; k < 4; k++) push_exp(32'hF0 + k, 1'b0);
    for (int k = 0; k < src_q[1].size(); k++) push_exp(src_q[1][k], 1'b1);
    resetn = 1'b1;
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
